collenda_clock_sequencer: RTL and testbench
===========================================

COLLENDA_CLOCK_SEQUENCER -- requirements
Module: collenda_clock_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: address  input  2  Avalon-MM slave word address.
REQ-004 SHALL have port: chipselect  input  1  slave select.
REQ-005 SHALL have port: write_n  input  1  active-low write strobe.
REQ-006 SHALL have port: writedata  input  32  write data.
REQ-007 SHALL have port: readdata  output  32  registered read data.
REQ-008 SHALL have port: ack_in  input  1  asynchronous acknowledge from the clocked device.
REQ-009 SHALL have port: clk_out  output  1  generated pulse train.
REQ-010 SHALL have port: irq  output  1  level interrupt, done AND irq_en.

Function
REQ-011 Register map SHALL be: addr0 write CTRL (bit0 start, bit1 abort, bit2 irq_en, bit3 done_clr); addr0 read STATUS {28'b0, ack_sync, irq_en, done, busy}; addr1 PULSE_COUNT[15:0] R/W; addr2 HALF_PERIOD[15:0] R/W; addr3 read REMAINING[15:0].
REQ-012 readdata SHALL be updated every clock from address, with one-cycle read latency; unused bits read 0.
REQ-013 A write occurs when chipselect=1 and write_n=0; writes to addr1/addr2 while busy SHALL be ignored.
REQ-014 ack_in SHALL pass through a 2-flop synchronizer to give ack_sync.
REQ-015 FSM states SHALL be IDLE, HIGH, LOW (plus WAIT_ACK, see REQ-027).
REQ-016 On a start write in IDLE at cycle T: REMAINING<=PULSE_COUNT, done<=0, busy=1; if PULSE_COUNT!=0, FSM SHALL enter HIGH at T+1 with clk_out=1.
REQ-017 A start with PULSE_COUNT=0 SHALL stay in IDLE, produce no pulse, and set done at T+1.
REQ-018 Each HIGH and each LOW phase SHALL last H=max(HALF_PERIOD,1) cycles via a 16-bit down-counter.
REQ-019 HIGH->LOW SHALL drive clk_out=0; at LOW end REMAINING SHALL decrement; if the result is 0 -> IDLE, done=1, otherwise -> HIGH.
REQ-020 A full sequence SHALL keep busy for exactly 2*N*H cycles (N=PULSE_COUNT), ack disabled.
REQ-021 A start write while busy SHALL be ignored.
REQ-022 Abort SHALL return to IDLE next cycle, clk_out=0, REMAINING unchanged, done not set.
REQ-023 Simultaneous start and abort SHALL be treated as abort only.
REQ-024 done_clr SHALL clear done; if done is set in the same cycle, set wins.
REQ-025 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-026 On reset_n=0: state IDLE, clk_out=0, readdata=0, irq=0, done=0, irq_en=0, PULSE_COUNT=0, HALF_PERIOD=0, REMAINING=0, synchronizer flops=0.

Configuration
REQ-027 With COLLENDA_CLKSEQ_ACK_EN defined: after each HIGH phase the FSM SHALL enter WAIT_ACK, hold clk_out=1 until ack_sync=1, then enter LOW. Abort SHALL also exit WAIT_ACK. Without the macro: WAIT_ACK is absent, ack_in is ignored, and HIGH goes directly to LOW.

Verification
REQ-028 PULSE_COUNT=3, HALF_PERIOD=2, start -> clk_out high/low 2 cycles each, 3 pulses, busy for 12 cycles, then done=1 and REMAINING=0.
REQ-029 PULSE_COUNT=0, start -> no clk_out edge; STATUS reads 0x2 two cycles after the write.
REQ-030 HALF_PERIOD=0, PULSE_COUNT=2 -> 1-cycle phases, busy for 4 cycles.
REQ-031 Mid-sequence abort with count 5 after 2 pulses -> clk_out=0 next cycle, busy=0, done=0, REMAINING=3.
REQ-032 irq_en=1, run to completion -> irq=1; done_clr -> irq=0; start+abort in the same write -> no pulse.
REQ-033 With ACK_EN, ack_in held low 10 cycles -> clk_out stays high; ack_in raised -> clk_out falls 3 cycles later (2 sync + 1).

Source files
------------

// File: rtl/collenda_clock_sequencer.sv
// Avalon-MM programmable pulse-train generator: N pulses of H-cycle high/low phases.
// Optional handshake feature: define COLLENDA_CLKSEQ_ACK_EN to stall each pulse's falling edge on ack_in.
module collenda_clock_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        ack_in,
    output logic        clk_out,
    output logic        irq
);

`ifdef COLLENDA_CLKSEQ_ACK_EN
    typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT_ACK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

    state_t      state_reg;
    logic [15:0] pulse_count_reg;
    logic [15:0] half_period_reg;
    logic [15:0] remaining_reg;
    logic [15:0] phase_cnt_reg;
    logic        done_reg;
    logic        irq_en_reg;
    logic        ack_meta_reg;
    logic        ack_sync_reg;
    logic        clk_out_reg;
    logic [31:0] readdata_reg;

    logic        wr_en;
    logic        ctrl_wr;
    logic        start;
    logic        abort;
    logic        busy;
    logic [15:0] phase_load;
    logic        unused_bits;

    assign wr_en   = chipselect & ~write_n;
    assign ctrl_wr = wr_en && (address == 2'd0);
    // Abort dominates a simultaneous start.
    assign abort   = ctrl_wr & writedata[1];
    assign start   = ctrl_wr & writedata[0] & ~writedata[1];
    assign busy    = (state_reg != IDLE);
    // Counter reload value: phase length minus one, with HALF_PERIOD=0 treated as 1.
    assign phase_load = (half_period_reg == 16'd0) ? 16'd0 : half_period_reg - 16'd1;
    assign unused_bits = ^writedata[31:16];

    assign readdata = readdata_reg;
    assign clk_out  = clk_out_reg;
    assign irq      = done_reg & irq_en_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            pulse_count_reg <= 16'd0;
            half_period_reg <= 16'd0;
            remaining_reg   <= 16'd0;
            phase_cnt_reg   <= 16'd0;
            done_reg        <= 1'b0;
            irq_en_reg      <= 1'b0;
            ack_meta_reg    <= 1'b0;
            ack_sync_reg    <= 1'b0;
            clk_out_reg     <= 1'b0;
            readdata_reg    <= 32'd0;
        end else begin
            ack_meta_reg <= ack_in;
            ack_sync_reg <= ack_meta_reg;

            if (ctrl_wr) begin
                irq_en_reg <= writedata[2];
                // Later assignments in the FSM override this, so a same-cycle set wins.
                if (writedata[3])
                    done_reg <= 1'b0;
            end
            if (wr_en && (address == 2'd1) && !busy)
                pulse_count_reg <= writedata[15:0];
            if (wr_en && (address == 2'd2) && !busy)
                half_period_reg <= writedata[15:0];

            case (address)
                2'd0:    readdata_reg <= {28'd0, ack_sync_reg, irq_en_reg, done_reg, busy};
                2'd1:    readdata_reg <= {16'd0, pulse_count_reg};
                2'd2:    readdata_reg <= {16'd0, half_period_reg};
                default: readdata_reg <= {16'd0, remaining_reg};
            endcase

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        remaining_reg <= pulse_count_reg;
                        done_reg      <= 1'b0;
                        if (pulse_count_reg != 16'd0) begin
                            state_reg     <= HIGH;
                            clk_out_reg   <= 1'b1;
                            phase_cnt_reg <= phase_load;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        clk_out_reg <= 1'b0;
                    end else if (phase_cnt_reg != 16'd0) begin
                        phase_cnt_reg <= phase_cnt_reg - 16'd1;
                    end else begin
`ifdef COLLENDA_CLKSEQ_ACK_EN
                        state_reg <= WAIT_ACK;
`else
                        state_reg     <= LOW;
                        clk_out_reg   <= 1'b0;
                        phase_cnt_reg <= phase_load;
`endif
                    end
                end
`ifdef COLLENDA_CLKSEQ_ACK_EN
                WAIT_ACK: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        clk_out_reg <= 1'b0;
                    end else if (ack_sync_reg) begin
                        state_reg     <= LOW;
                        clk_out_reg   <= 1'b0;
                        phase_cnt_reg <= phase_load;
                    end
                end
`endif
                LOW: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        clk_out_reg <= 1'b0;
                    end else if (phase_cnt_reg != 16'd0) begin
                        phase_cnt_reg <= phase_cnt_reg - 16'd1;
                    end else begin
                        remaining_reg <= remaining_reg - 16'd1;
                        if (remaining_reg == 16'd1) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= HIGH;
                            clk_out_reg   <= 1'b1;
                            phase_cnt_reg <= phase_load;
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    clk_out_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collenda_clock_sequencer.sv
// Directed-vector bench for collenda_clock_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_collenda_clock_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ack_in;
    logic        clk_out;
    logic        irq;

    int applied;
    int miscompares;

    collenda_clock_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .ack_in     (ack_in),
        .clk_out    (clk_out),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; the write is captured by the next rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        applied++;
        if ({clk_out, irq} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_outputs: clk_out/irq=%b required 00", {clk_out, irq});
        end
        applied++;
        if (readdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_readdata: got %h required 0", readdata);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            applied++;
            if (d !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got %h required 0", a, d);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic_train;
        logic [31:0] d;
        logic        exp_clk;
        logic        exp_busy;
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 14; i++) begin
            exp_clk  = (i < 12) && (((i / 2) % 2) == 0);
            exp_busy = (i < 12);
            applied++;
            if (clk_out !== exp_clk || dut.busy !== exp_busy) begin
                miscompares++;
                $display("FAIL basic_cycle%0d: clk_out=%b busy=%b required %b %b",
                         i, clk_out, dut.busy, exp_clk, exp_busy);
            end
            @(negedge clk);
        end
        rd(2'd0, d);
        applied++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL basic_status: got %h required 2", d);
        end
        rd(2'd3, d);
        applied++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL basic_remaining: got %h required 0", d);
        end
        rd(2'd1, d);
        applied++;
        if (d !== 32'd3) begin
            miscompares++;
            $display("FAIL basic_pulse_count: got %h required 3", d);
        end
        $display("test_basic_train: done");
    endtask

    task automatic test_zero_count;
        logic [31:0] d;
        wr(2'd0, 32'h8);
        rd(2'd0, d);
        applied++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_cleared: got %h required 0", d);
        end
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        applied++;
        if (clk_out !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_clk_out: got %b required 0", clk_out);
        end
        rd(2'd0, d);
        applied++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL zero_status: got %h required 2", d);
        end
        applied++;
        if (clk_out !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_clk_out_late: got %b required 0", clk_out);
        end
        $display("test_zero_count: done");
    endtask

    task automatic test_min_half;
        logic exp_clk;
        logic exp_busy;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 6; i++) begin
            exp_clk  = (i < 4) && ((i % 2) == 0);
            exp_busy = (i < 4);
            applied++;
            if (clk_out !== exp_clk || dut.busy !== exp_busy) begin
                miscompares++;
                $display("FAIL minhalf_cycle%0d: clk_out=%b busy=%b required %b %b",
                         i, clk_out, dut.busy, exp_clk, exp_busy);
            end
            @(negedge clk);
        end
        $display("test_min_half: done");
    endtask

    task automatic test_abort;
        logic [31:0] d;
        wr(2'd2, 32'd2);
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h1);
        repeat (8) @(negedge clk);
        applied++;
        if (clk_out !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_third_pulse: clk_out=%b required 1", clk_out);
        end
        wr(2'd0, 32'h2);
        applied++;
        if (clk_out !== 1'b0 || dut.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_stop: clk_out=%b busy=%b required 0 0", clk_out, dut.busy);
        end
        rd(2'd0, d);
        applied++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_status: got %h required 0", d);
        end
        rd(2'd3, d);
        applied++;
        if (d !== 32'd3) begin
            miscompares++;
            $display("FAIL abort_remaining: got %h required 3", d);
        end
        $display("test_abort: done");
    endtask

    task automatic test_busy_ignore;
        logic [31:0] d;
        int          k;
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1);
        wr(2'd1, 32'd7);
        wr(2'd2, 32'd9);
        wr(2'd0, 32'h1);
        k = 4;
        while (dut.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        applied++;
        if (k !== 13) begin
            miscompares++;
            $display("FAIL busy_length: idle at sample %0d required 13", k);
        end
        rd(2'd1, d);
        applied++;
        if (d !== 32'd2) begin
            miscompares++;
            $display("FAIL busy_pc_write: got %h required 2", d);
        end
        rd(2'd2, d);
        applied++;
        if (d !== 32'd3) begin
            miscompares++;
            $display("FAIL busy_hp_write: got %h required 3", d);
        end
        $display("test_busy_ignore: done");
    endtask

    task automatic test_irq;
        logic [31:0] d;
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h5);
        @(negedge clk);
        // done_clr lands on the same edge that sets done
        wr(2'd0, 32'hC);
        applied++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_set_wins: irq=%b required 1", irq);
        end
        rd(2'd0, d);
        applied++;
        if (d !== 32'h6) begin
            miscompares++;
            $display("FAIL irq_status: got %h required 6", d);
        end
        wr(2'd0, 32'hC);
        applied++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: irq=%b required 0", irq);
        end
        wr(2'd0, 32'h7);
        for (int i = 0; i < 3; i++) begin
            applied++;
            if (clk_out !== 1'b0 || dut.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL start_abort_cycle%0d: clk_out=%b busy=%b required 0 0",
                         i, clk_out, dut.busy);
            end
            @(negedge clk);
        end
        rd(2'd0, d);
        applied++;
        if (d !== 32'h4) begin
            miscompares++;
            $display("FAIL start_abort_status: got %h required 4", d);
        end
        $display("test_irq: done");
    endtask

`ifdef COLLENDA_CLKSEQ_ACK_EN
    task automatic test_ack;
        int k;
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            applied++;
            if (clk_out !== 1'b1) begin
                miscompares++;
                $display("FAIL ack_hold%0d: clk_out=%b required 1", i, clk_out);
            end
        end
        ack_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            applied++;
            if (clk_out !== (i < 3)) begin
                miscompares++;
                $display("FAIL ack_release%0d: clk_out=%b required %b", i, clk_out, (i < 3));
            end
        end
        k = 0;
        while (dut.busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        applied++;
        if (dut.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_finish: busy=%b required 0", dut.busy);
        end
        ack_in = 1'b0;
        repeat (3) @(negedge clk);
        $display("test_ack: done");
    endtask
`endif

    initial begin
        applied     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'd0;
        ack_in      = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic_train;
        test_zero_count;
        test_min_half;
        test_abort;
        test_busy_ignore;
        test_irq;
`ifdef COLLENDA_CLKSEQ_ACK_EN
        test_ack;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
